// File: rtl/tanh_share_pkg.sv
// Shared widths, default tanh unit latency and the per-operation tag that
// follows each operand through the shared unit.
package tanh_share_pkg;
  localparam int FP16_W    = 16;
  localparam int TANH_LAT  = 4;
  localparam int MAX_NREQ  = 8;
  localparam int TAG_IDX_W = $clog2(MAX_NREQ);

  typedef struct packed {
    logic                 valid;
    logic [TAG_IDX_W-1:0] idx;
  } tag_t;
endpackage

// File: rtl/tanh_share_ctrl_rr_arbiter.sv
// Round-robin pick: first asserted request at or above ptr, wrapping.
// Produces a one-hot grant, its index and a grant-present flag.
module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);
  logic [IDX_W-1:0] idx;

  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    idx       = '0;
    for (int off = 0; off < NREQ; off++) begin
      idx = IDX_W'((int'(ptr) + off) % NREQ);
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt[idx]  = 1'b1;
        gnt_idx   = idx;
      end
    end
  end
endmodule

// File: rtl/tanh_share_ctrl.sv
// Shares one pipelined fp16 tanh unit among NREQ requesters with round-robin
// issue and tag-tracked return. Optional macro TANH_SHARE_IDLE_GATE_EN gates
// the unit enable when nothing is issuing or in flight.
module tanh_share_ctrl
  import tanh_share_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int LAT  = TANH_LAT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [FP16_W*NREQ-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [FP16_W*NREQ-1:0] rsp_data,
  input  logic [NREQ-1:0]        rsp_ready,
  output logic [FP16_W-1:0]      tu_in,
  output logic                   tu_enable,
  input  logic [FP16_W-1:0]      tu_out
);
  localparam int IDX_W = $clog2(NREQ);

  logic [NREQ-1:0]        busy_q, busy_d;
  logic [NREQ-1:0]        rsp_valid_q, rsp_valid_d;
  logic [FP16_W*NREQ-1:0] rsp_data_q, rsp_data_d;
  logic [FP16_W-1:0]      tu_in_q, tu_in_d;
  logic [IDX_W-1:0]       rr_q, rr_d;
  // Stage 0 sits beside the tu_in register; stages 1..LAT track the unit.
  tag_t                   tag_q [LAT+1];
  tag_t                   tag_d [LAT+1];

  logic [NREQ-1:0]  eligible;
  logic [NREQ-1:0]  gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             enable;

  assign eligible = req_valid & ~busy_q & {NREQ{~rst}};

  rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
    .req       (eligible),
    .ptr       (rr_q),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

`ifdef TANH_SHARE_IDLE_GATE_EN
  logic any_tag;
  always_comb begin
    any_tag = 1'b0;
    for (int i = 0; i <= LAT; i++) any_tag = any_tag | tag_q[i].valid;
  end
  assign enable = !rst && (gnt_valid || any_tag);
`else
  assign enable = !rst;
`endif

  always_comb begin
    tu_in_d     = tu_in_q;
    rr_d        = rr_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q & ~rsp_ready;
    busy_d      = (busy_q & ~(rsp_valid_q & rsp_ready)) | gnt;
    for (int i = 0; i <= LAT; i++) tag_d[i] = tag_q[i];

    if (gnt_valid) begin
      tu_in_d = req_data[int'(gnt_idx)*FP16_W +: FP16_W];
      rr_d    = (int'(gnt_idx) == NREQ-1) ? '0 : gnt_idx + IDX_W'(1);
    end

    if (enable) begin
      tag_d[0].valid = gnt_valid;
      tag_d[0].idx   = TAG_IDX_W'(gnt_idx);
      for (int i = 1; i <= LAT; i++) tag_d[i] = tag_q[i-1];
      if (tag_q[LAT].valid) begin
        for (int i = 0; i < NREQ; i++) begin
          if (tag_q[LAT].idx == TAG_IDX_W'(i)) begin
            rsp_valid_d[i]                    = 1'b1;
            rsp_data_d[i*FP16_W +: FP16_W]    = tu_out;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q      <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      tu_in_q     <= '0;
      rr_q        <= '0;
      for (int i = 0; i <= LAT; i++) tag_q[i] <= '0;
    end else begin
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      tu_in_q     <= tu_in_d;
      rr_q        <= rr_d;
      for (int i = 0; i <= LAT; i++) tag_q[i] <= tag_d[i];
    end
  end

  assign req_ready = gnt;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign tu_in     = tu_in_q;
  assign tu_enable = enable;
endmodule

// File: tb/tb_tanh_share_ctrl.sv
// Bench for tanh_share_ctrl: a stand-in tanh unit plus a request/response
// reference model kept as per-requester state and an issue-order queue.
module tb_tanh_share_ctrl;
  localparam int NREQ = 4;
  localparam int LAT  = 4;
  localparam int W    = 16;
  localparam int MODE_RR   = 0;
  localparam int MODE_BP   = 1;
  localparam int MODE_RAND = 2;
`ifdef TANH_SHARE_IDLE_GATE_EN
  localparam bit GATED = 1'b1;
`else
  localparam bit GATED = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [W*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [W*NREQ-1:0] rsp_data;
  logic [NREQ-1:0]   rsp_ready = '0;
  logic [W-1:0]      tu_in;
  logic              tu_enable;
  logic [W-1:0]      tu_out;

  int errors = 0;
  int checks = 0;
  int edge_n = 0;

  // Reference model state
  logic [NREQ-1:0] m_busy = '0;
  logic [NREQ-1:0] m_rsp_valid = '0;
  logic [W-1:0]    m_rsp_data [NREQ] = '{default: 16'h0};
  int              m_rr = 0;
  logic [W-1:0]    exp_q [$];
  int              idx_q [$];
  int              due_q [$];

  logic [W-1:0] u_stage [LAT] = '{default: 16'h0};

  tanh_share_ctrl #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready),
    .tu_in     (tu_in),
    .tu_enable (tu_enable),
    .tu_out    (tu_out)
  );

  always #5 clk = ~clk;

  // Stand-in tanh: saturates to +/-1.0 for |x| >= 4.0, small-signal identity otherwise.
  function automatic logic [W-1:0] tanh_ref(input logic [W-1:0] x);
    if (x[14:0] >= 15'h4400) return {x[15], 15'h3C00};
    return x;
  endfunction

  always @(posedge clk) begin
    if (tu_enable) begin
      for (int s = LAT-1; s > 0; s--) u_stage[s] <= u_stage[s-1];
      u_stage[0] <= tanh_ref(tu_in);
    end
  end
  assign tu_out = u_stage[LAT-1];

  function automatic logic [NREQ-1:0] model_grant();
    logic [NREQ-1:0] oh;
    oh = '0;
    if (rst) return oh;
    for (int off = 0; off < NREQ; off++) begin
      int k;
      k = (m_rr + off) % NREQ;
      if (req_valid[k] && !m_busy[k]) begin
        oh[k] = 1'b1;
        return oh;
      end
    end
    return oh;
  endfunction

  always @(posedge clk) begin
    logic [NREQ-1:0] g;
    g = model_grant();
    edge_n = edge_n + 1;
    if (rst) begin
      m_busy = '0;
      m_rsp_valid = '0;
      m_rr = 0;
      exp_q.delete();
      idx_q.delete();
      due_q.delete();
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (m_rsp_valid[i] && rsp_ready[i]) begin
          m_rsp_valid[i] = 1'b0;
          m_busy[i] = 1'b0;
        end
      end
      if (due_q.size() > 0 && due_q[0] == edge_n) begin
        m_rsp_valid[idx_q[0]] = 1'b1;
        m_rsp_data[idx_q[0]]  = exp_q[0];
        void'(exp_q.pop_front());
        void'(idx_q.pop_front());
        void'(due_q.pop_front());
      end
      for (int i = 0; i < NREQ; i++) begin
        if (g[i]) begin
          m_busy[i] = 1'b1;
          m_rr = (i + 1) % NREQ;
          exp_q.push_back(tanh_ref(req_data[i*W +: W]));
          idx_q.push_back(i);
          due_q.push_back(edge_n + 1 + LAT);
        end
      end
    end
  end

  task automatic test_reset();
    req_valid = '1;
    rsp_ready = '1;
    req_data  = {NREQ{16'h1234}};
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
      checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
      checks++; if (rsp_data !== '0) begin errors++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
      checks++; if (tu_in !== '0) begin errors++; $display("FAIL reset_tu_in got=%h exp=0", tu_in); end
      checks++; if (tu_enable !== 1'b0) begin errors++; $display("FAIL reset_tu_enable got=%b exp=0", tu_enable); end
    end
    rst = 1'b0;
    req_valid = '0;
  endtask

  task automatic test_single();
    int          t_idx  [3] = '{0, 2, 2};
    logic [W-1:0] t_data [3] = '{16'h4800, 16'hC800, 16'h0000};
    logic [W-1:0] t_exp  [3] = '{16'h3C00, 16'hBC00, 16'h0000};
    for (int t = 0; t < 3; t++) begin
      int idx;
      int hs;
      int n;
      logic [NREQ-1:0] oh;
      idx = t_idx[t];
      oh = '0;
      oh[idx] = 1'b1;
      @(negedge clk);
      rsp_ready = '1;
      checks++; if (tu_enable !== !GATED) begin errors++; $display("FAIL single_idle_enable t=%0d got=%b exp=%b", t, tu_enable, !GATED); end
      req_data[idx*W +: W] = t_data[t];
      req_valid = oh;
      #1;
      checks++; if (req_ready !== oh) begin errors++; $display("FAIL single_grant t=%0d got=%b exp=%b", t, req_ready, oh); end
      checks++; if (tu_enable !== 1'b1) begin errors++; $display("FAIL single_issue_enable t=%0d got=%b exp=1", t, tu_enable); end
      @(negedge clk);
      hs = edge_n;
      req_valid = '0;
      n = 0;
      while (!rsp_valid[idx] && n < 20) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (!rsp_valid[idx]) begin
        errors++; $display("FAIL single_timeout t=%0d got=no_rsp exp=rsp within 20 cycles", t);
      end else begin
        checks++; if (edge_n - hs != LAT + 1) begin errors++; $display("FAIL single_latency t=%0d got=%0d exp=%0d", t, edge_n - hs, LAT + 1); end
        checks++; if (rsp_data[idx*W +: W] !== t_exp[t]) begin errors++; $display("FAIL single_data t=%0d got=%h exp=%h", t, rsp_data[idx*W +: W], t_exp[t]); end
      end
      @(negedge clk);
      checks++; if (rsp_valid[idx] !== 1'b0) begin errors++; $display("FAIL single_rsp_clear t=%0d got=%b exp=0", t, rsp_valid[idx]); end
      req_valid = oh;
      #1;
      checks++; if (req_ready !== oh) begin errors++; $display("FAIL single_busy_clear t=%0d got=%b exp=%b", t, req_ready, oh); end
      req_valid = '0;
    end
  endtask

  task automatic test_traffic(input int mode, input int cycles);
    int last_g = -1;
    int g1 = 0;
    int g_other = 0;
    logic [NREQ-1:0] exp_g;
    logic exp_en;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      exp_g  = model_grant();
      exp_en = !rst && (!GATED || (exp_g != '0) || ((m_busy & ~m_rsp_valid) != '0));
      checks++; if (req_ready !== exp_g) begin errors++; $display("FAIL traffic_grant mode=%0d cyc=%0d got=%b exp=%b", mode, c, req_ready, exp_g); end
      for (int i = 0; i < NREQ; i++) begin
        checks++; if (rsp_valid[i] !== m_rsp_valid[i]) begin errors++; $display("FAIL traffic_rsp_valid mode=%0d cyc=%0d req=%0d got=%b exp=%b", mode, c, i, rsp_valid[i], m_rsp_valid[i]); end
        if (m_rsp_valid[i]) begin
          checks++; if (rsp_data[i*W +: W] !== m_rsp_data[i]) begin errors++; $display("FAIL traffic_rsp_data mode=%0d cyc=%0d req=%0d got=%h exp=%h", mode, c, i, rsp_data[i*W +: W], m_rsp_data[i]); end
        end
      end
      checks++; if (tu_enable !== exp_en) begin errors++; $display("FAIL traffic_enable mode=%0d cyc=%0d got=%b exp=%b", mode, c, tu_enable, exp_en); end
      checks++; if ((req_ready & rsp_valid & rsp_ready) !== '0) begin errors++; $display("FAIL grant_accept_collision mode=%0d cyc=%0d got=%b exp=0", mode, c, req_ready & rsp_valid & rsp_ready); end
      if (mode == MODE_RR) begin
        for (int i = 0; i < NREQ; i++) begin
          if (req_ready[i]) begin
            if (last_g >= 0) begin
              checks++; if (i != (last_g + 1) % NREQ) begin errors++; $display("FAIL rr_order cyc=%0d got=%0d exp=%0d", c, i, (last_g + 1) % NREQ); end
            end
            last_g = i;
          end
        end
      end
      if (mode == MODE_BP && c < 20) begin
        g1 += int'(req_ready[1]);
        g_other += $countones(req_ready) - int'(req_ready[1]);
      end
      for (int i = 0; i < NREQ; i++) req_data[i*W +: W] = 16'($urandom);
      if (c >= cycles - 12) begin
        req_valid = '0;
        rsp_ready = '1;
      end else if (mode == MODE_RR) begin
        req_valid = '1;
        rsp_ready = '1;
      end else if (mode == MODE_BP) begin
        req_valid = '1;
        rsp_ready = (c < 19) ? 4'b1101 : 4'b1111;
      end else begin
        req_valid = 4'($urandom_range(0, 15));
        rsp_ready = 4'($urandom_range(0, 15));
      end
    end
    if (mode == MODE_BP) begin
      checks++; if (g1 != 1) begin errors++; $display("FAIL bp_req1_grants got=%0d exp=1", g1); end
      checks++; if (g_other < 6) begin errors++; $display("FAIL bp_other_grants got=%0d exp>=6", g_other); end
    end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    rsp_ready = '1;
    req_valid = '1;
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < NREQ; i++) req_data[i*W +: W] = 16'($urandom);
      @(negedge clk);
    end
    rst = 1'b1;
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int c = 0; c < 12; c++) begin
      checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL midrst_rsp_valid cyc=%0d got=%b exp=0", c, rsp_valid); end
      checks++; if (rsp_data !== '0) begin errors++; $display("FAIL midrst_rsp_data cyc=%0d got=%h exp=0", c, rsp_data); end
      checks++; if (tu_in !== '0) begin errors++; $display("FAIL midrst_tu_in cyc=%0d got=%h exp=0", c, tu_in); end
      checks++; if (req_ready !== '0) begin errors++; $display("FAIL midrst_req_ready cyc=%0d got=%b exp=0", c, req_ready); end
      checks++; if (tu_enable !== !GATED) begin errors++; $display("FAIL midrst_enable cyc=%0d got=%b exp=%b", c, tu_enable, !GATED); end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_traffic(MODE_RR, 60);
    test_traffic(MODE_BP, 50);
    test_traffic(MODE_RAND, 300);
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end
endmodule
